// File: rtl/ack_bus_pkg.sv
// Shared definitions for the ack bus schedulers: module IDs, request width and
// scheduler state encoding.
package ack_bus_pkg;

    localparam int unsigned REQ_W = 4;

    localparam logic [1:0] ID_MEM  = 2'b00;
    localparam logic [1:0] ID_SHA  = 2'b01;
    localparam logic [1:0] ID_AES  = 2'b10;
    localparam logic [1:0] ID_CTRL = 2'b11;
    localparam logic [1:0] ID_NONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RELEASE
    } state_e;

    function automatic logic [REQ_W-1:0] id_to_onehot(input logic [1:0] id);
        logic [REQ_W-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: search starts at ptr+1 and wraps,
// first set request wins.
module rr_pick4
    import ack_bus_pkg::*;
(
    input  logic [REQ_W-1:0] req,
    input  logic [1:0]       ptr,
    output logic [1:0]       id,
    output logic             valid
);

    logic [1:0] cand;

    always_comb begin
        id    = ID_NONE;
        valid = 1'b0;
        cand  = ptr;
        for (int i = 1; i <= int'(REQ_W); i++) begin
            cand = ptr + 2'(i);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                id    = cand;
            end
        end
    end

endmodule

// File: rtl/ack_bus_rr_scheduler.sv
// Registered round-robin scheduler for the shared ack bus: grants are held until
// ack_done, requester abort, or a hold timeout, followed by a 1-cycle turnaround.
module ack_bus_rr_scheduler
    import ack_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_mem,
    input  logic       req_sha,
    input  logic       req_aes,
    input  logic       req_ctrl,
    input  logic       ack_done,
    output logic       ack_ready_to_mem,
    output logic       ack_ready_to_sha,
    output logic       ack_ready_to_aes,
    output logic       ack_ready_to_ctrl,
    output logic [1:0] winner_source_id,
    output logic       winner_valid,
    output logic       ack_event,
    output logic       timeout_err
);

    // CNT_W is zero when the timeout is disabled; keep at least one bit of storage.
    localparam int unsigned HoldW = (CNT_W > 0) ? CNT_W : 1;
    localparam logic [HoldW-1:0] HoldMax =
        HoldW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       winner_q, winner_d;
    logic [REQ_W-1:0] ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             timeout_err_q, timeout_err_d;

    logic [REQ_W-1:0] req_vec;
    logic [1:0]       pick_id;
    logic             pick_valid;
    logic             abort, tmo;

    assign req_vec   = {req_ctrl, req_aes, req_sha, req_mem};
    assign ack_event = |req_vec;

    rr_pick4 u_pick (
        .req   (req_vec),
        .ptr   (rr_ptr_q),
        .id    (pick_id),
        .valid (pick_valid)
    );

    assign abort = !req_vec[winner_q];
    assign tmo   = (TIMEOUT_CYCLES != 0) && (hold_cnt_q == HoldMax);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        hold_cnt_d    = hold_cnt_q;
        winner_d      = winner_q;
        ready_d       = ready_q;
        valid_d       = valid_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                if (pick_valid) begin
                    state_d    = HOLD;
                    rr_ptr_d   = pick_id;
                    hold_cnt_d = '0;
                    winner_d   = pick_id;
                    ready_d    = id_to_onehot(pick_id);
                    valid_d    = 1'b1;
                end else begin
                    state_d  = IDLE;
                    winner_d = ID_NONE;
                    ready_d  = '0;
                    valid_d  = 1'b0;
                end
            end
            HOLD: begin
                if (ack_done || abort || tmo) begin
                    state_d  = RELEASE;
                    winner_d = ID_NONE;
                    ready_d  = '0;
                    valid_d  = 1'b0;
                    // Completion and abort both take precedence over the timeout.
                    timeout_err_d = tmo && !ack_done && !abort;
                end else if (hold_cnt_q != HoldMax) begin
                    hold_cnt_d = hold_cnt_q + HoldW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 2'b11;
            hold_cnt_q    <= '0;
            winner_q      <= ID_NONE;
            ready_q       <= '0;
            valid_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            winner_q      <= winner_d;
            ready_q       <= ready_d;
            valid_q       <= valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign ack_ready_to_mem  = ready_q[ID_MEM];
    assign ack_ready_to_sha  = ready_q[ID_SHA];
    assign ack_ready_to_aes  = ready_q[ID_AES];
    assign ack_ready_to_ctrl = ready_q[ID_CTRL];
    assign winner_source_id  = winner_q;
    assign winner_valid      = valid_q;
    assign timeout_err       = timeout_err_q;

endmodule

// File: tb/tb_ack_bus_rr_scheduler.sv
// Directed, table-driven bench for ack_bus_rr_scheduler with hand-computed expectations.
module tb_ack_bus_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic       req_mem, req_sha, req_aes, req_ctrl;
    logic       ack_done;
    logic       ack_ready_to_mem, ack_ready_to_sha, ack_ready_to_aes, ack_ready_to_ctrl;
    logic [1:0] winner_source_id;
    logic       winner_valid;
    logic       ack_event;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    ack_bus_rr_scheduler #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_mem           (req_mem),
        .req_sha           (req_sha),
        .req_aes           (req_aes),
        .req_ctrl          (req_ctrl),
        .ack_done          (ack_done),
        .ack_ready_to_mem  (ack_ready_to_mem),
        .ack_ready_to_sha  (ack_ready_to_sha),
        .ack_ready_to_aes  (ack_ready_to_aes),
        .ack_ready_to_ctrl (ack_ready_to_ctrl),
        .winner_source_id  (winner_source_id),
        .winner_valid      (winner_valid),
        .ack_event         (ack_event),
        .timeout_err       (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] rdy;
        logic [1:0] id;
        logic       vld;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] req, input logic done, input logic [3:0] rdy,
                                input logic [1:0] id, input logic vld, input logic err);
        vec_t v;
        v.req = req; v.done = done; v.rdy = rdy; v.id = id; v.vld = vld; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] rdy, input logic [1:0] id,
                              input logic vld, input logic err);
        chk({tag, " ready"},
            {ack_ready_to_ctrl, ack_ready_to_aes, ack_ready_to_sha, ack_ready_to_mem}, rdy);
        chk({tag, " id"}, {2'b00, winner_source_id}, {2'b00, id});
        chk({tag, " valid"}, {3'b000, winner_valid}, {3'b000, vld});
        chk({tag, " timeout_err"}, {3'b000, timeout_err}, {3'b000, err});
    endtask

    // Drive inputs, check ack_event combinationally, then check registered outputs after the edge.
    task automatic step(input string tag, input logic [3:0] req, input logic done,
                        input logic [3:0] rdy, input logic [1:0] id, input logic vld,
                        input logic err);
        logic [3:0] any;
        {req_ctrl, req_aes, req_sha, req_mem} = req;
        ack_done = done;
        any = {3'b000, |req};
        #1;
        chk({tag, " ack_event"}, {3'b000, ack_event}, any);
        @(posedge clk);
        #1;
        check_outs(tag, rdy, id, vld, err);
    endtask

    initial begin
        rst_n = 1'b0;
        {req_ctrl, req_aes, req_sha, req_mem} = 4'b0000;
        ack_done = 1'b0;

        // All four requesting, done one cycle after each grant: mem, sha, aes, ctrl, mem.
        add(4'b1111, 0, 4'b0001, 2'b00, 1, 0);
        add(4'b1111, 1, 4'b0000, 2'b11, 0, 0);
        add(4'b1111, 0, 4'b0010, 2'b01, 1, 0);
        add(4'b1111, 1, 4'b0000, 2'b11, 0, 0);
        add(4'b1111, 0, 4'b0100, 2'b10, 1, 0);
        add(4'b1111, 1, 4'b0000, 2'b11, 0, 0);
        add(4'b1111, 0, 4'b1000, 2'b11, 1, 0);
        add(4'b1111, 1, 4'b0000, 2'b11, 0, 0);
        add(4'b1111, 0, 4'b0001, 2'b00, 1, 0);
        add(4'b0000, 1, 4'b0000, 2'b11, 0, 0);
        add(4'b0000, 0, 4'b0000, 2'b11, 0, 0);
        // Single sha transaction with 1-cycle grant latency, then back to idle.
        add(4'b0010, 0, 4'b0010, 2'b01, 1, 0);
        add(4'b0010, 0, 4'b0010, 2'b01, 1, 0);
        add(4'b0010, 0, 4'b0010, 2'b01, 1, 0);
        add(4'b0010, 0, 4'b0010, 2'b01, 1, 0);
        add(4'b0000, 1, 4'b0000, 2'b11, 0, 0);
        add(4'b0000, 0, 4'b0000, 2'b11, 0, 0);
        // ack_done while idle has no effect.
        add(4'b0000, 1, 4'b0000, 2'b11, 0, 0);
        // mem aborts while ctrl is pending: no error, ctrl granted after turnaround.
        add(4'b0001, 0, 4'b0001, 2'b00, 1, 0);
        add(4'b1001, 0, 4'b0001, 2'b00, 1, 0);
        add(4'b1000, 0, 4'b0000, 2'b11, 0, 0);
        add(4'b1000, 0, 4'b1000, 2'b11, 1, 0);
        add(4'b0000, 1, 4'b0000, 2'b11, 0, 0);
        add(4'b0000, 0, 4'b0000, 2'b11, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 4'b0000, 2'b11, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].done, vecs[i].rdy, vecs[i].id,
                 vecs[i].vld, vecs[i].err);
        end

        // Timeout: aes held 16 cycles, forced release with error, sha wins the next pick.
        for (int k = 0; k < 16; k++) begin
            step($sformatf("tmo_hold%0d", k), 4'b0100, 0, 4'b0100, 2'b10, 1, 0);
        end
        step("tmo_release", 4'b0100, 0, 4'b0000, 2'b11, 0, 1);
        step("tmo_next_sha", 4'b0110, 0, 4'b0010, 2'b01, 1, 0);
        step("tmo_done", 4'b0000, 1, 4'b0000, 2'b11, 0, 0);
        step("tmo_idle", 4'b0000, 0, 4'b0000, 2'b11, 0, 0);

        // Done coincides with timeout threshold: no error; lone aes is re-granted.
        for (int k = 0; k < 16; k++) begin
            step($sformatf("dt_hold%0d", k), 4'b0100, 0, 4'b0100, 2'b10, 1, 0);
        end
        step("dt_release", 4'b0100, 1, 4'b0000, 2'b11, 0, 0);
        step("dt_regrant_aes", 4'b0100, 0, 4'b0100, 2'b10, 1, 0);
        step("dt_done", 4'b0000, 1, 4'b0000, 2'b11, 0, 0);
        step("dt_idle", 4'b0000, 0, 4'b0000, 2'b11, 0, 0);

        // Reset in the middle of a grant clears outputs without waiting for a clock.
        step("rst_grant_ctrl", 4'b1111, 0, 4'b1000, 2'b11, 1, 0);
        step("rst_hold_ctrl", 4'b1111, 0, 4'b1000, 2'b11, 1, 0);
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 4'b0000, 2'b11, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        step("rst_first_mem", 4'b1111, 0, 4'b0001, 2'b00, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
